// File: rtl/irb_dw_ctrl.sv
// Depthwise-stage tap sequencer: walks output pixels x kernel taps, drives FMINT/KDW reads
// and the delayed MAC strobes. Optional stride-2 support is built when DW_STRIDE2_EN is defined.
module irb_dw_ctrl #(
  parameter int Nkx    = 3,
  parameter int Nky    = 3,
  parameter int Tix_T  = 9,
  parameter int Tiy_T  = 9,
  parameter int Tox_T  = 7,
  parameter int Toy_T  = 7,
  parameter int RD_LAT = 1,
  localparam int FA_W  = $clog2(Tix_T * Tiy_T),
  localparam int KA_W  = $clog2(Nkx * Nky),
  localparam int FO_W  = $clog2(Tox_T * Toy_T)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      n_ox,
  input  logic [2:0]      n_oy,
  input  logic            stride2,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            rd_en,
  output logic [FA_W-1:0] fmint_addr,
  output logic [KA_W-1:0] kdw_addr,
  output logic            tap_valid,
  output logic            tap_first,
  output logic            tap_last,
  output logic [FO_W-1:0] fmo_addr
);

  localparam int KX_W = (Nkx > 1) ? $clog2(Nkx) : 1;
  localparam int KY_W = (Nky > 1) ? $clog2(Nky) : 1;
  localparam int DR_W = $clog2(RD_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [3:0] LIM1_X = 4'(Tox_T);
  localparam logic [3:0] LIM1_Y = 4'(Toy_T);

  logic [1:0]      state_q, state_d;
  logic [KX_W-1:0] kx_q, kx_d;
  logic [KY_W-1:0] ky_q, ky_d;
  logic [2:0]      ox_q, ox_d, oy_q, oy_d;
  logic [2:0]      nx_q, nx_d, ny_q, ny_d;
  logic [DR_W-1:0] drain_q, drain_d;
  logic            done_q, done_d, err_q, err_d;
  logic [3:0]      lim_x, lim_y;
  logic            cfg_ok;
  logic            kx_last, ky_last, ox_last, oy_last;
  logic [FA_W-1:0] row_c, col_c;
  logic [FO_W-1:0] fmo_c;

`ifdef DW_STRIDE2_EN
  localparam logic [3:0] LIM2_X = 4'((Tix_T - Nkx) / 2 + 1);
  localparam logic [3:0] LIM2_Y = 4'((Tiy_T - Nky) / 2 + 1);
  logic s2_q, s2_d;

  always_comb begin
    lim_x = stride2 ? LIM2_X : LIM1_X;
    lim_y = stride2 ? LIM2_Y : LIM1_Y;
    row_c = (FA_W'(oy_q) << s2_q) + FA_W'(ky_q);
    col_c = (FA_W'(ox_q) << s2_q) + FA_W'(kx_q);
  end
`else
  logic unused_stride2;
  assign unused_stride2 = stride2;

  always_comb begin
    lim_x = LIM1_X;
    lim_y = LIM1_Y;
    row_c = FA_W'(oy_q) + FA_W'(ky_q);
    col_c = FA_W'(ox_q) + FA_W'(kx_q);
  end
`endif

  assign cfg_ok  = (n_ox != 3'd0) && (n_oy != 3'd0) &&
                   ({1'b0, n_ox} <= lim_x) && ({1'b0, n_oy} <= lim_y);
  assign kx_last = (kx_q == KX_W'(Nkx - 1));
  assign ky_last = (ky_q == KY_W'(Nky - 1));
  assign ox_last = (ox_q == nx_q - 3'd1);
  assign oy_last = (oy_q == ny_q - 3'd1);

  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
`ifdef DW_STRIDE2_EN
    s2_d    = s2_q;
`endif
    drain_d = drain_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            nx_d    = n_ox;
            ny_d    = n_oy;
`ifdef DW_STRIDE2_EN
            s2_d    = stride2;
`endif
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Counters wrap to zero on the final tap, so IDLE/DRAIN present address 0.
        if (!kx_last) begin
          kx_d = kx_q + 1'b1;
        end else begin
          kx_d = '0;
          if (!ky_last) begin
            ky_d = ky_q + 1'b1;
          end else begin
            ky_d = '0;
            if (!ox_last) begin
              ox_d = ox_q + 3'd1;
            end else begin
              ox_d = '0;
              if (!oy_last) begin
                oy_d = oy_q + 3'd1;
              end else begin
                oy_d    = '0;
                drain_d = '0;
                state_d = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DR_W'(RD_LAT - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    nx_q <= nx_d;
    ny_q <= ny_d;
`ifdef DW_STRIDE2_EN
    s2_q <= s2_d;
`endif
  end

  assign rd_en      = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign fmint_addr = row_c * FA_W'(Tix_T) + col_c;
  assign kdw_addr   = KA_W'(ky_q) * KA_W'(Nkx) + KA_W'(kx_q);
  assign fmo_c      = FO_W'(oy_q) * FO_W'(Tox_T) + FO_W'(ox_q);

  // Strobe pipe: stage i holds the tap issued i+1 cycles ago, matching RAM read latency.
  logic            vld_q   [RD_LAT];
  logic            first_q [RD_LAT];
  logic            last_q  [RD_LAT];
  logic [FO_W-1:0] fmo_q   [RD_LAT];
  logic            vld_d   [RD_LAT];
  logic            first_d [RD_LAT];
  logic            last_d  [RD_LAT];
  logic [FO_W-1:0] fmo_d   [RD_LAT];

  always_comb begin
    vld_d[0]   = rd_en;
    first_d[0] = rd_en && (kx_q == '0) && (ky_q == '0);
    last_d[0]  = rd_en && kx_last && ky_last;
    fmo_d[0]   = rd_en ? fmo_c : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      first_d[i] = first_q[i-1];
      last_d[i]  = last_q[i-1];
      fmo_d[i]   = fmo_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i]   <= 1'b0;
        first_q[i] <= 1'b0;
        last_q[i]  <= 1'b0;
        fmo_q[i]   <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
      fmo_q   <= fmo_d;
    end
  end

  assign tap_valid = vld_q[RD_LAT-1];
  assign tap_first = first_q[RD_LAT-1];
  assign tap_last  = last_q[RD_LAT-1];
  assign fmo_addr  = fmo_q[RD_LAT-1];

endmodule
